dmem_responder: RTL

// - Data-memory responder for the pipelined MIPS core's MEM stage.
// - Accepts read/write requests driven by the core and serves them from an

---
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM stage of the pipelined MIPS core.
//   Serves load/store requests from an internal word-organised RAM after
//   LATENCY wait states and stalls the pipeline until the access completes.
//
//   Parameters
//     ADDR_W   word-address bits, RAM depth = 2**ADDR_W words of 32 bits
//     LATENCY  wait-state cycles per access (0..15)
//
//   Ports
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-high reset
//     DMemRead      in   load request
//     DMemWrite     in   store request (wins over DMemRead)
//     DMemaddr      in   byte address, word index = DMemaddr[ADDR_W+1:2]
//     DMemin        in   store data, byte-lane aligned
//     DMemByteEn    in   byte-lane enables for stores
//     DMemout       out  load data, registered, holds until next read
//     DMemReady     out  one-cycle completion pulse
//     DMemStall     out  combinational pipeline hold
//     DMemMisalign  out  alignment fault pulse with DMemReady
//
//   Optional feature macro: DMEM_MISALIGN_EXC_EN
//     When defined, misaligned accesses are suppressed (RAM and DMemout
//     untouched) and flagged on DMemMisalign. When undefined the port is
//     absent and addr[1:0] is ignored.

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DMemRead,
    input  logic        DMemWrite,
    input  logic [31:0] DMemaddr,
    input  logic [31:0] DMemin,
    input  logic [3:0]  DMemByteEn,
    output logic [31:0] DMemout,
    output logic        DMemReady,
    output logic        DMemStall
`ifdef DMEM_MISALIGN_EXC_EN
    ,
    output logic        DMemMisalign
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT_V = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t nextState_s;
    state_t state_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addrLat_r;
    logic [31:0]       dataLat_r;
    logic [3:0]        beLat_r;
    logic              writeLat_r;
    logic [31:0]       mem_r [DEPTH];

    logic              req_s;
    logic              goDone_s;
    logic              accessOk_s;
    logic [ADDR_W-1:0] opIdx_s;
    logic [31:0]       opData_s;
    logic [3:0]        opBe_s;
    logic              opWrite_s;

    assign req_s = DMemRead | DMemWrite;

`ifdef DMEM_MISALIGN_EXC_EN
    logic [1:0] addrLowLat_r;
    logic [1:0] opLow_s;
    logic       misaligned_s;
    logic       unusedAddrBits_s;

    // Alignment rule: full words need addr[1:0]==0, halfwords need addr[0]==0.
    function automatic logic isMisaligned(input logic [3:0] be, input logic [1:0] low);
        return ((be == 4'hF) && (low != 2'b00)) ||
               (((be == 4'h3) || (be == 4'hC)) && low[0]);
    endfunction

    assign unusedAddrBits_s = ^DMemaddr[31:ADDR_W+2];
    assign misaligned_s     = isMisaligned(opBe_s, opLow_s);
    assign accessOk_s       = ~misaligned_s;
`else
    logic unusedAddrBits_s;
    assign unusedAddrBits_s = ^{DMemaddr[31:ADDR_W+2], DMemaddr[1:0]};
    assign accessOk_s       = 1'b1;
`endif

    // Access operands: live inputs while accepting in IDLE (needed when
    // LATENCY=0 goes straight to DONE), latched copies afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            opIdx_s   = DMemaddr[ADDR_W+1:2];
            opData_s  = DMemin;
            opBe_s    = DMemByteEn;
            opWrite_s = DMemWrite;
`ifdef DMEM_MISALIGN_EXC_EN
            opLow_s   = DMemaddr[1:0];
`endif
        end else begin
            opIdx_s   = addrLat_r;
            opData_s  = dataLat_r;
            opBe_s    = beLat_r;
            opWrite_s = writeLat_r;
`ifdef DMEM_MISALIGN_EXC_EN
            opLow_s   = addrLowLat_r;
`endif
        end
    end

    // Next-state logic for the IDLE -> WAIT -> DONE -> IDLE handshake.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    nextState_s = (LATENCY > 0) ? WAIT : DONE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // The RAM access happens on the edge that enters DONE.
    assign goDone_s = (nextState_s == DONE);

    // Stall output: asserted while a request waits in IDLE or in WAIT; low in DONE.
    always_comb begin
        DMemStall = 1'b0;
        case (state_r)
            IDLE:    DMemStall = req_s;
            WAIT:    DMemStall = 1'b1;
            DONE:    DMemStall = 1'b0;
            default: DMemStall = 1'b0;
        endcase
    end

    // State, wait counter and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addrLat_r  <= '0;
            dataLat_r  <= 32'd0;
            beLat_r    <= 4'd0;
            writeLat_r <= 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
            addrLowLat_r <= 2'b00;
`endif
        end else begin
            state_r <= nextState_s;
            if ((state_r == IDLE) && req_s) begin
                cnt_r      <= LAT_V;
                addrLat_r  <= DMemaddr[ADDR_W+1:2];
                dataLat_r  <= DMemin;
                beLat_r    <= DMemByteEn;
                writeLat_r <= DMemWrite;
`ifdef DMEM_MISALIGN_EXC_EN
                addrLowLat_r <= DMemaddr[1:0];
`endif
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Registered completion outputs and load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            DMemout   <= 32'd0;
            DMemReady <= 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
            DMemMisalign <= 1'b0;
`endif
        end else begin
            DMemReady <= goDone_s;
`ifdef DMEM_MISALIGN_EXC_EN
            DMemMisalign <= goDone_s & misaligned_s;
`endif
            if (goDone_s && !opWrite_s && accessOk_s) begin
                DMemout <= mem_r[opIdx_s];
            end
        end
    end

    // RAM write port with byte lanes; contents survive reset, but a reset
    // on the completing edge discards the pending store.
    always_ff @(posedge clk) begin
        if (!rst && goDone_s && opWrite_s && accessOk_s) begin
            for (int i = 0; i < 4; i++) begin
                if (opBe_s[i]) begin
                    mem_r[opIdx_s][8*i +: 8] <= opData_s[8*i +: 8];
                end
            end
        end
    end

endmodule
